// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one MAC TX stream, with an idle gap after every frame.
// Optional stall watchdog that aborts a stuck frame: define MAC_TX_ARB_WATCHDOG_EN.
module mac_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_PORTS      = 4,
    parameter int GAP_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    input  logic                            m_axis_trdy,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            busy
);
    localparam int ID_W     = $clog2(NUM_PORTS);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_GAP, ST_ABORT} state_t;

    state_t            state_r, state_s;
    logic [ID_W-1:0]   grant_r, grant_s;
    logic [ID_W-1:0]   pick_s, idx_s;
    logic              found_s, hit_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              xfer_s;
    logic              stall_hit_s;

    assign xfer_s   = (state_r == ST_PASS) && s_axis_tvalid[grant_r] && m_axis_trdy;
    assign grant_id = grant_r;
    assign busy     = (state_r != ST_IDLE);

    // Round-robin scan starting just above the last granted port.
    always_comb begin
        pick_s  = grant_r;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx_s   = ID_W'((int'(grant_r) + i) % NUM_PORTS);
            hit_s   = !found_s && s_axis_tvalid[idx_s];
            pick_s  = hit_s ? idx_s : pick_s;
            found_s = found_s | hit_s;
        end
    end

`ifdef MAC_TX_ARB_WATCHDOG_EN
    localparam int SC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [SC_W-1:0] stall_cnt_r;

    assign stall_hit_s = (state_r == ST_PASS) && !xfer_s &&
                         (stall_cnt_r == SC_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive PASS cycles without a transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_r <= '0;
        end else if ((state_r != ST_PASS) || xfer_s || stall_hit_s) begin
            stall_cnt_r <= '0;
        end else begin
            stall_cnt_r <= stall_cnt_r + SC_W'(1);
        end
    end
`else
    assign stall_hit_s = 1'b0 && (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and output decode; outputs are only live while passing or aborting.
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        s_axis_trdy   = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_PASS;
                    grant_s = pick_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                m_axis_tdata         = s_axis_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tvalid        = s_axis_tvalid[grant_r];
                m_axis_tlast         = s_axis_tlast[grant_r];
                s_axis_trdy[grant_r] = m_axis_trdy;
                if (xfer_s && s_axis_tlast[grant_r]) begin
                    state_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else if (stall_hit_s) begin
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_ABORT: begin
`ifdef MAC_TX_ARB_WATCHDOG_EN
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                if (m_axis_trdy) begin
                    state_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    state_s = ST_ABORT;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and gap counter registers; the counter loads on GAP entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= ID_W'(NUM_PORTS - 1);
            gap_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            if ((state_s == ST_GAP) && (state_r != ST_GAP)) begin
                gap_cnt_r <= GAP_W'(GAP_LOAD);
            end else if ((state_r == ST_GAP) && (gap_cnt_r != '0)) begin
                gap_cnt_r <= gap_cnt_r - GAP_W'(1);
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: a 12-cycle-gap instance plus a zero-gap instance.
module tb_mac_tx_arbiter;
    localparam int DW  = 8;
    localparam int NP  = 4;
    localparam int GAP = 12;
    localparam int TO  = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [1:0] port;
        int         space;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [DW-1:0]  d [NP];
    logic           v [NP];
    logic           l [NP];
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]  s_tvalid, s_tlast, s_trdy;
    logic [DW-1:0]  m_tdata;
    logic           m_tvalid, m_tlast, m_tuser, m_trdy;
    logic [1:0]     grant_id;
    logic           busy;

    logic [NP*DW-1:0] z_sdata;
    logic [NP-1:0]  z_svalid, z_slast, z_strdy;
    logic [DW-1:0]  z_tdata;
    logic           z_tvalid, z_tlast, z_tuser;
    logic [1:0]     z_grant;
    logic           z_busy;
    logic [DW-1:0]  zd;
    logic           zv, zl;

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign s_tdata[g*DW +: DW] = d[g];
        assign s_tvalid[g]         = v[g];
        assign s_tlast[g]          = l[g];
    end
    assign z_sdata  = {{(NP-1)*DW{1'b0}}, zd};
    assign z_svalid = {{(NP-1){1'b0}}, zv};
    assign z_slast  = {{(NP-1){1'b0}}, zl};

    mac_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_trdy(m_trdy), .grant_id(grant_id), .busy(busy));

    mac_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(z_sdata), .s_axis_tvalid(z_svalid), .s_axis_tlast(z_slast), .s_axis_trdy(z_strdy),
        .m_axis_tdata(z_tdata), .m_axis_tvalid(z_tvalid), .m_axis_tlast(z_tlast), .m_axis_tuser(z_tuser),
        .m_axis_trdy(1'b1), .grant_id(z_grant), .busy(z_busy));

    int   vecs = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t zq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ok(input string name, input bit ok, input int act, input int exp);
        vecs++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input int p, input logic [7:0] base, input int len, input bit term, input int space);
        for (int b = 0; b < len; b++) begin
            exp_t e;
            e.data  = 8'(base + b);
            e.last  = term && (b == len - 1);
            e.user  = 1'b0;
            e.port  = 2'(p);
            e.space = (b == 0) ? space : -1;
            q.push_back(e);
        end
    endtask

    // Source model: presents beats on port p and advances on each observed handshake.
    task automatic drive(input int p, input logic [7:0] base, input int len, input bit term, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        for (int b = 0; b < len; b++) begin
            bit hs;
            int guard;
            d[p] = 8'(base + b);
            l[p] = term && (b == len - 1);
            v[p] = 1'b1;
            hs = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                if (!reset_n) begin
                    v[p] = 1'b0; l[p] = 1'b0;
                    return;
                end
                hs = s_trdy[p];
                guard++;
                if (guard > 300) begin
                    check_ok("handshake_timeout", 1'b0, guard, 300);
                    v[p] = 1'b0; l[p] = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
        end
        v[p] = 1'b0;
        l[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    // Monitor for the gapped instance: beat contents and frame spacing.
    int last_end = 0;
    bit have_prev = 1'b0, in_frame = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            have_prev = 1'b0;
            in_frame  = 1'b0;
        end else if (m_tvalid && m_trdy) begin
            if (q.size() == 0) begin
                check("unexpected_beat", {20'h0, m_tuser, m_tlast, grant_id, m_tdata}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("beat", {20'h0, m_tuser, m_tlast, grant_id, m_tdata}, {20'h0, e.user, e.last, e.port, e.data});
                if (!in_frame && have_prev) begin
                    if (e.space >= 0) check_ok("frame_spacing", (cyc - last_end) == e.space, cyc - last_end, e.space);
                    else check_ok("min_spacing", (cyc - last_end) >= GAP + 2, cyc - last_end, GAP + 2);
                end
                in_frame = !m_tlast;
                if (m_tlast) begin
                    have_prev = 1'b1;
                    last_end  = cyc;
                end
            end
        end
    end

    // Monitor for the zero-gap instance.
    int z_end = 0;
    bit z_prev = 1'b0, z_in = 1'b0;
    always @(negedge clk) begin
        if (reset_n && z_tvalid) begin
            if (zq.size() == 0) begin
                check("z_unexpected_beat", {23'h0, z_tlast, z_tdata}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = zq.pop_front();
                check("z_beat", {21'h0, z_tuser, z_tlast, z_grant, z_tdata}, {21'h0, e.user, e.last, e.port, e.data});
                if (!z_in && z_prev) check_ok("z_spacing", (cyc - z_end) == 2, cyc - z_end, 2);
                z_in = !z_tlast;
                if (z_tlast) begin
                    z_prev = 1'b1;
                    z_end  = cyc;
                end
            end
        end
    end

    logic [3:0] pat;

    initial begin
        reset_n = 1'b0;
        m_trdy  = 1'b1;
        zv = 1'b0; zl = 1'b0; zd = '0;
        pat = 4'b1001;
        for (int p = 0; p < NP; p++) begin
            d[p] = '0; v[p] = 1'b0; l[p] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_trdy", {28'h0, s_trdy}, 32'h0);
        check("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("rst_tlast", {31'h0, m_tlast}, 32'h0);
        check("rst_tuser", {31'h0, m_tuser}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_grant", {30'h0, grant_id}, 32'h3);
        check("rst_z_grant", {30'h0, z_grant}, 32'h3);

        // Single 5-byte frame from port 2, then the gap.
        push_frame(2, 8'h11, 5, 1'b1, -1);
        fork
            drive(2, 8'h11, 5, 1'b1, 0);
            begin
                @(posedge clk); #1;
                check("grant_latency", {30'h0, grant_id}, 32'h2);
                check("busy_in_pass", {31'h0, busy}, 32'h1);
            end
        join
        for (int i = 0; i < GAP; i++) begin
            check("busy_in_gap", {31'h0, busy}, 32'h1);
            check("tvalid_in_gap", {31'h0, m_tvalid}, 32'h0);
            @(posedge clk); #1;
        end
        check("busy_after_gap", {31'h0, busy}, 32'h0);

        // Three simultaneous requesters from reset priority: served 0, 1, 3.
        do_reset();
        push_frame(0, 8'h21, 3, 1'b1, -1);
        push_frame(1, 8'h31, 3, 1'b1, GAP + 2);
        push_frame(3, 8'h41, 3, 1'b1, GAP + 2);
        fork
            drive(0, 8'h21, 3, 1'b1, 0);
            drive(1, 8'h31, 3, 1'b1, 0);
            drive(3, 8'h41, 3, 1'b1, 0);
        join
        repeat (14) @(posedge clk);
        #1;

        // Backpressure on port 1 while port 0 requests mid-frame.
        push_frame(1, 8'h51, 4, 1'b1, -1);
        push_frame(0, 8'h61, 2, 1'b1, GAP + 2);
        fork
            drive(1, 8'h51, 4, 1'b1, 0);
            drive(0, 8'h61, 2, 1'b1, 3);
            begin
                for (int i = 0; i < 12; i++) begin
                    m_trdy = pat[i % 4];
                    @(posedge clk); #1;
                end
                m_trdy = 1'b1;
            end
            begin
                repeat (5) @(posedge clk);
                #1 check("no_preempt", {30'h0, grant_id}, 32'h1);
            end
        join
        repeat (14) @(posedge clk);
        #1;

        // Reset lands while beat 3 of an 8-beat frame is presented.
        push_frame(3, 8'h81, 2, 1'b0, -1);
        fork
            drive(3, 8'h81, 8, 1'b1, 0);
            begin
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk); #1;
                check("midrst_trdy", {28'h0, s_trdy}, 32'h0);
                check("midrst_tvalid", {31'h0, m_tvalid}, 32'h0);
                check("midrst_tlast", {31'h0, m_tlast}, 32'h0);
                check("midrst_busy", {31'h0, busy}, 32'h0);
                check("midrst_grant", {30'h0, grant_id}, 32'h3);
                reset_n = 1'b1;
            end
        join
        check("midrst_queue", q.size(), 32'h0);

        // Zero-gap instance: continuous 2-beat frames from port 0.
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 2; b++) begin
                exp_t e;
                e.data = 8'(8'hA0 + 2*f + b); e.last = (b == 1); e.user = 1'b0; e.port = 2'd0; e.space = -1;
                zq.push_back(e);
            end
        end
        zv = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 2; b++) begin
                bit hs;
                int guard;
                zd = 8'(8'hA0 + 2*f + b);
                zl = (b == 1);
                hs = 1'b0;
                guard = 0;
                while (!hs && guard < 50) begin
                    @(negedge clk);
                    hs = z_strdy[0];
                    guard++;
                    @(posedge clk); #1;
                end
                check_ok("z_handshake", hs, guard, 50);
                if (b == 1) begin
                    check("z_idle_busy", {31'h0, z_busy}, 32'h0);
                    check("z_idle_tvalid", {31'h0, z_tvalid}, 32'h0);
                end
            end
        end
        zv = 1'b0;
        zl = 1'b0;

`ifdef MAC_TX_ARB_WATCHDOG_EN
        // Port 2 stalls after two beats; watchdog aborts, then port 3 gets served.
        repeat (3) @(posedge clk);
        #1;
        push_frame(2, 8'h91, 2, 1'b0, -1);
        begin
            exp_t e;
            e.data = 8'h00; e.last = 1'b1; e.user = 1'b1; e.port = 2'd2; e.space = -1;
            q.push_back(e);
        end
        push_frame(3, 8'hB1, 2, 1'b1, GAP + 2);
        fork
            drive(2, 8'h91, 2, 1'b0, 0);
            drive(3, 8'hB1, 2, 1'b1, 5);
        join
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'h0);
        check("z_queue_drained", zq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errors);
        $finish;
    end
endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single MAC TX datapath between NUM_PORTS AXI-Stream frame sources (for example UDP, ARP and ICMP engines).
- A grant is held from the first beat until the beat carrying tlast. The block then enforces a programmable idle gap before the next arbitration, so the MAC always sees whole, back-to-back-safe frames.
- Sits between the protocol engines and the TX async FIFO / tx MAC.

Parameters:
- DATA_WIDTH, 8, byte lane width of every stream.
- NUM_PORTS, 4, number of requesting input streams (2..8).
- GAP_CYCLES, 12, idle cycles inserted after each frame's tlast (0 = no gap).
- TIMEOUT_CYCLES, 1024, stall limit for the optional watchdog.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed input data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tlast  in  NUM_PORTS  per-port last-beat flag
- s_axis_trdy  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  DATA_WIDTH  selected data
- m_axis_tvalid  out  1  selected valid
- m_axis_tlast  out  1  selected last
- m_axis_tuser  out  1  frame-abort flag, qualified with tlast
- m_axis_trdy  in  1  downstream ready
- grant_id  out  $clog2(NUM_PORTS)  currently or last granted port
- busy  out  1  high in PASS or GAP

Behaviour:
- Reset values: s_axis_trdy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, grant_id=NUM_PORTS-1 (so port 0 has first priority), state=IDLE.
- FSM states: IDLE, PASS, GAP.
- IDLE:
  - All s_axis_trdy=0; m_axis_tvalid=0.
  - If any s_axis_tvalid bit is set, choose the first asserted port scanning upward from grant_id+1 modulo NUM_PORTS.
  - Register it into grant_id and go to PASS next cycle. Arbitration latency is one cycle.
  - No tvalid: remain in IDLE.
- PASS:
  - Combinational pass-through of the granted port: m_axis_tdata/tvalid/tlast = granted port's signals.
  - s_axis_trdy[grant_id] = m_axis_trdy; all other trdy bits are 0. m_axis_tuser=0.
  - A transfer is tvalid && trdy. A transfer with tlast=1 moves to GAP, or to IDLE if GAP_CYCLES=0.
  - Gaps in the granted port's tvalid mid-frame keep the grant; there is no preemption.
  - Requests from other ports are ignored until the frame ends.
- GAP:
  - All trdy=0; m_axis_tvalid=0.
  - A down-counter is loaded with GAP_CYCLES-1 on entry. Exit to IDLE when the counter is 0, giving exactly GAP_CYCLES cycles in GAP.
  - Minimum spacing between last beat of frame N and first beat of frame N+1 is therefore GAP_CYCLES+2 cycles when the sink is always ready.
- Round-robin:
  - After a grant to port k, port k is lowest priority in the next arbitration.
  - A single requester is re-granted repeatedly, with the gap between frames.
- Single-beat frame (tvalid and tlast on the first beat) is legal: PASS lasts one cycle if m_axis_trdy=1.
- Backpressure: m_axis_trdy=0 holds data on the granted port. The arbiter adds no buffering and no skid.
- Reset asserted mid-frame: the block returns to reset values the next clock edge. The partial frame is abandoned; handling it downstream is the FIFO's responsibility.
- busy = (state != IDLE).

Optional Feature:
- Macro: MAC_TX_ARB_WATCHDOG_EN.
- Defined:
  - In PASS, a counter increments on every cycle without a transfer and clears on any transfer.
  - When it reaches TIMEOUT_CYCLES, the block drives one beat with m_axis_tvalid=1, tlast=1, tuser=1, tdata=0, and waits for m_axis_trdy.
  - During that beat s_axis_trdy[grant_id]=0. The block then enters GAP.
  - The source's remaining beats are later seen as a new frame.
- Undefined: no counter is built, m_axis_tuser is tied to 0, and a stalled source holds the grant indefinitely.

Test Plan:
- Reset, then port 2 sends a 5-byte frame 0x11..0x15, sink always ready -> grant_id=2 one cycle after tvalid; 5 output beats with tlast on 0x15; 12 idle cycles; busy falls after the gap.
- Ports 0,1,3 all request 3-byte frames simultaneously -> output order 0,1,3; each frame intact; 12-cycle gaps between frames.
- Port 1 frame with m_axis_trdy toggling 1,0,0,1 -> no data lost or duplicated; port 0 request arriving mid-frame is not granted until after tlast plus gap.
- Port 0 requests continuously with GAP_CYCLES=0 -> consecutive frames separated by exactly one IDLE cycle.
- Reset asserted on beat 3 of an 8-beat frame -> next cycle all outputs at reset values; grant_id=NUM_PORTS-1.
- (MAC_TX_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16) port 2 stops tvalid after 2 beats -> after 16 stall cycles, an abort beat with tlast=1, tuser=1; then GAP; then another requester can be granted.
